mux_n_arb: RTL and testbench
============================

# mux_n_arb

Parametrised N-input, W-bit registered selector with valid/ready handshake; the successor to the fixed 4:1 single-bit mux. Used on the KGP-RISC datapath wherever several producers share one consumer, e.g. ALU/shifter/load results into writeback. Channel choice comes either from an explicit select (MODE 0) or from a round-robin arbiter over valid inputs (MODE 1). One output register stage decouples producer and consumer timing.

## Interface
- `WIDTH`, 32, data width per channel (≥1)
- `NUM_IN`, 4, number of input channels (≥2, need not be a power of two)
- `MODE`, 0, 0 = explicit select, 1 = round-robin arbitration
- `SEL_W` is a derived localparam, $clog2(NUM_IN); not overridable
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  NUM_IN*WIDTH  packed inputs; channel k at [k*WIDTH +: WIDTH]
- `in_valid`  in  NUM_IN  per-channel valid
- `in_ready`  out  NUM_IN  per-channel ready; at most one bit high per cycle
- `sel`  in  SEL_W  channel select; used only in MODE 0, ignored in MODE 1
- `out_data`  out  WIDTH  registered selected data
- `out_src`  out  SEL_W  index of the channel that supplied out_data
- `out_valid`  out  1  output holds a valid item
- `out_ready`  in  1  consumer accepts item this cycle

## Operation
- `can_accept = !out_valid || out_ready`.
- Transfer on channel k: `in_valid[k] && in_ready[k]`. Output transfer: `out_valid && out_ready`.
- MODE 0: candidate = `sel`. `in_ready[sel] = can_accept`, all other bits 0. If `sel >= NUM_IN`, all `in_ready` are 0 and nothing is accepted.
- MODE 1: a priority pointer `ptr`, reset 0, selects the first valid channel searching `ptr, ptr+1, …, NUM_IN-1, 0, …` (wraps modulo NUM_IN, not 2^SEL_W).
  - Only the granted channel's `in_ready` equals `can_accept`; all others are 0.
  - On a transfer from channel g, `ptr <= (g+1) mod NUM_IN`. With no transfer, `ptr` holds, including when output is stalled.
- On a transfer, `out_data <= channel data`, `out_src <= channel index`, `out_valid <= 1`.
- On an output transfer with no input transfer, `out_valid <= 0`. `out_data` and `out_src` hold their last values.
- While `out_valid && !out_ready`, `out_data`, `out_src` and `out_valid` stay stable.
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `ptr=0`. Reset mid-stall drops the held item. `rst` takes priority over every other event in the same cycle.

## Timing
- Latency: one cycle from input transfer to `out_valid`.
- Throughput: one item per cycle when `out_ready` is held high. A simultaneous output and input transfer replaces the held item with no bubble.
- `in_ready` is combinational from `out_valid`, `out_ready`, `sel` (MODE 0) and `in_valid`/`ptr` (MODE 1). No `in_ready` path depends on `in_data`.
- `out_*` outputs are registers only, with no combinational path from inputs.
- Producers must hold `in_data`/`in_valid` until they see ready. The block does not check this.

## Structure
- Shared package/include `kgp_mux_pkg`: `MUX_MODE_SEL=0`, `MUX_MODE_RR=1`. It also holds the function that picks channel k out of the packed bus.
- Sub-module `rr_arbiter` (NUM_IN): inputs `req`, `advance`, `clk`, `rst`.
  - Outputs a one-hot `grant` and an encoded `grant_idx`.
  - Owns `ptr` and the wrap-around search.
  - Instantiated only when MODE=1; a generate branch selects it.
- Top level owns the output register and the ready logic.

## Test plan
- Reset, then MODE 0, W=32, N=4, `sel=2`, `in_valid=4'b0100`, ch2=0xDEADBEEF, `out_ready=1`. Required: `in_ready=4'b0100`; next cycle `out_valid=1`, `out_data=0xDEADBEEF`, `out_src=2`.
- Stall: hold `out_ready=0` for 3 cycles with a new item on `sel=1`. Required: `in_ready=0`, `out_data` unchanged. Raise `out_ready`: item transfers and the new item appears the following cycle, with no gap.
- MODE 1, N=3, all `in_valid=1`, `out_ready=1` for 6 cycles. Required: `out_src` sequence 0,1,2,0,1,2. Then with `in_valid=3'b101` after ch1 is granted: next grants are 2, then 0.
- N=3 MODE 0 with `sel=3`. Required: `in_ready=0`, `out_valid` stays 0.
- Assert `rst` while `out_valid=1` and `out_ready=0`. Required: next cycle `out_valid=0`, `out_data=0`, `out_src=0`, and the MODE 1 pointer back at 0, so the next grant with all valid goes to ch0.
- Back-to-back streaming, W=8, 16 items, `out_ready` random 50%. Required: scoreboard shows every accepted item exactly once, in order, with the correct `out_src`.

Source files
------------

// File: rtl/kgp_mux_pkg.sv
// Shared definitions for the KGP-RISC N-input selector: mode encodings and
// the helper that extracts one channel from a packed multi-channel bus.
package kgp_mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Upper bounds for the channel-extraction helper; instances must fit inside.
    localparam int MAX_BUS_W  = 4096;
    localparam int MAX_CHAN_W = 1024;

    function automatic logic [MAX_CHAN_W-1:0] pick_chan(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   width
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[MAX_CHAN_W-1:0];
    endfunction

endpackage

// File: rtl/mux_n_arb_chk.sv
// Handshake invariants for mux_n_arb: single ready, held output while stalled,
// and a source index that always names a real channel.
module mux_n_arb_chk #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] in_ready,
    input  logic [WIDTH-1:0]  out_data,
    input  logic [SEL_W-1:0]  out_src,
    input  logic              out_valid,
    input  logic              out_ready
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready));

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

    a_src_range: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (int'(out_src) < NUM_IN));

endmodule

// File: rtl/mux_n_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo NUM_IN; ptr moves past the winner only when the grant is consumed.
module rr_arbiter
    import kgp_mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic             found_s;

    // Wrap-around search starting at the priority pointer
    always_comb begin
        int cand;
        cand      = 0;
        found_s   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end else begin
                cand = cand;
            end
            if (!found_s && req[cand]) begin
                found_s   = 1'b1;
                grant_idx = SEL_W'(cand);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot form of the winning index
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Pointer steps past the winner on a consumed grant, otherwise holds
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found_s) begin
            if (int'(grant_idx) == NUM_IN - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SEL_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_n_arb.sv
// N-input, W-bit registered selector with valid/ready handshake. Channel choice is
// an explicit select (MODE 0) or round-robin over valid inputs (MODE 1).
module mux_n_arb
    import kgp_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    parameter  int MODE   = MUX_MODE_SEL,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [NUM_IN-1:0] in_ready_s;
    logic [SEL_W-1:0]  cand_idx_s;
    logic [WIDTH-1:0]  cand_data_s;
    logic              can_accept_s;
    logic              xfer_in_s;

    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  out_data_d;
    logic [SEL_W-1:0]  out_src_q;
    logic [SEL_W-1:0]  out_src_d;
    logic              out_valid_q;
    logic              out_valid_d;

    assign can_accept_s = !out_valid_q || out_ready;
    assign xfer_in_s    = |(in_valid & in_ready_s);
    assign cand_data_s  = WIDTH'(pick_chan(MAX_BUS_W'(in_data), int'(cand_idx_s), WIDTH));

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [NUM_IN-1:0] grant_s;
            logic              unused_sel_s;

            rr_arbiter #(
                .NUM_IN (NUM_IN)
            ) u_arb (
                .clk       (clk),
                .rst       (rst),
                .req       (in_valid),
                .advance   (xfer_in_s),
                .grant     (grant_s),
                .grant_idx (cand_idx_s)
            );

            assign in_ready_s   = grant_s & {NUM_IN{can_accept_s}};
            assign unused_sel_s = ^sel;
        end else begin : g_sel
            logic sel_ok_s;

            assign cand_idx_s = sel;
            // Selects beyond the last channel (non power-of-two NUM_IN) accept nothing
            assign sel_ok_s   = (int'(sel) < NUM_IN);

            // Only the selected channel may see ready
            always_comb begin
                in_ready_s = '0;
                if (sel_ok_s) begin
                    in_ready_s[sel] = can_accept_s;
                end else begin
                    in_ready_s = '0;
                end
            end
        end
    endgenerate

    // Output stage: load on input transfer, empty on drain, otherwise hold
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (xfer_in_s) begin
            out_data_d  = cand_data_s;
            out_src_d   = cand_idx_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

    mux_n_arb_chk #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready_s),
        .out_data  (out_data_q),
        .out_src   (out_src_q),
        .out_valid (out_valid_q),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_mux_n_arb.sv
// Bench for mux_n_arb: directed select/stall/round-robin/reset steps plus a
// randomized round-robin stream scored against a queue-based reference model.
module tb_mux_n_arb;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: MODE 0, W=32, N=4
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_sel, a_out_src;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready;
    // B: MODE 1, W=8, N=3
    logic [23:0]  b_in_data;
    logic [2:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_sel, b_out_src;
    logic [7:0]   b_out_data;
    logic         b_out_valid, b_out_ready;
    // C: MODE 0, W=8, N=3
    logic [23:0]  c_in_data;
    logic [2:0]   c_in_valid, c_in_ready;
    logic [1:0]   c_sel, c_out_src;
    logic [7:0]   c_out_data;
    logic         c_out_valid, c_out_ready;

    mux_n_arb #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_src(a_out_src), .out_valid(a_out_valid), .out_ready(a_out_ready));

    mux_n_arb #(.WIDTH(8), .NUM_IN(3), .MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_src(b_out_src), .out_valid(b_out_valid), .out_ready(b_out_ready));

    mux_n_arb #(.WIDTH(8), .NUM_IN(3), .MODE(0)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_src(c_out_src), .out_valid(c_out_valid), .out_ready(c_out_ready));

    // reference-model state for the randomized stream
    int         ptr_m;
    logic       ov_m;
    int         q_src[$];
    int         q_data[$];
    logic       pend[3];
    logic [7:0] pdata[3];
    int         issued;
    int         popped;
    int         cyc;
    int         g;
    int         exp_src;
    int         exp_data;
    logic       rdy;
    logic [2:0] exp_rdy;
    logic [2:0] one3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // first valid channel searching p, p+1, ... wrapping modulo 3; -1 if none
    function automatic int rr_pick(input logic [2:0] v, input int p);
        for (int i = 0; i < 3; i++) begin
            if (v[(p + i) % 3]) return (p + i) % 3;
        end
        return -1;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        one3    = 3'b001;
        rst = 1'b1;
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_data",  64'(a_out_data),  64'd0);
        check("rst_a_src",   64'(a_out_src),   64'd0);
        check("rst_b_valid", 64'(b_out_valid), 64'd0);

        // MODE 0 single transfer
        a_sel = 2'd2;
        a_in_valid = 4'b0100;
        a_in_data[64 +: 32] = 32'hDEADBEEF;
        a_out_ready = 1'b1;
        #1;
        check("sel_in_ready", 64'(a_in_ready), 64'(4'b0100));
        step();
        check("sel_out_valid", 64'(a_out_valid), 64'd1);
        check("sel_out_data",  64'(a_out_data),  64'hDEADBEEF);
        check("sel_out_src",   64'(a_out_src),   64'd2);

        // stall with a new item waiting on sel=1
        a_in_valid = 4'b0010;
        a_sel = 2'd1;
        a_in_data[32 +: 32] = 32'h12345678;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 64'(a_in_ready), 64'd0);
            step();
            check("stall_out_data",  64'(a_out_data),  64'hDEADBEEF);
            check("stall_out_src",   64'(a_out_src),   64'd2);
            check("stall_out_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 64'(a_in_ready), 64'(4'b0010));
        step();
        check("unstall_out_valid", 64'(a_out_valid), 64'd1);
        check("unstall_out_data",  64'(a_out_data),  64'h12345678);
        check("unstall_out_src",   64'(a_out_src),   64'd1);
        a_in_valid = 4'b0000;
        step();
        check("drain_out_valid", 64'(a_out_valid), 64'd0);
        check("drain_out_data",  64'(a_out_data),  64'h12345678);

        // MODE 0, N=3, out-of-range select
        c_sel = 2'd3;
        c_in_valid = 3'b111;
        c_in_data = 24'h332211;
        c_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("sel3_in_ready", 64'(c_in_ready), 64'd0);
            step();
            check("sel3_out_valid", 64'(c_out_valid), 64'd0);
        end
        c_in_valid = 3'b000;

        // MODE 1 round robin, all valid
        b_in_data = {8'hA2, 8'hA1, 8'hA0};
        b_in_valid = 3'b111;
        b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_in_ready", 64'(b_in_ready), 64'(one3 << (i % 3)));
            step();
            check("rr_out_src",  64'(b_out_src),  64'(i % 3));
            check("rr_out_data", 64'(b_out_data), 64'(8'hA0 + 8'(i % 3)));
        end
        // ch1 was just granted; with 101 the order is 2 then 0
        b_in_valid = 3'b101;
        for (int i = 0; i < 2; i++) begin
            exp_src = (i == 0) ? 2 : 0;
            #1;
            check("rr101_in_ready", 64'(b_in_ready), 64'(one3 << exp_src));
            step();
            check("rr101_out_src", 64'(b_out_src), 64'(exp_src));
        end

        // reset while stalled; ptr (currently 1) must return to 0
        b_in_valid = 3'b111;
        b_out_ready = 1'b0;
        step();
        check("pre_rst_valid", 64'(b_out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_valid", 64'(b_out_valid), 64'd0);
        check("post_rst_data",  64'(b_out_data),  64'd0);
        check("post_rst_src",   64'(b_out_src),   64'd0);
        b_out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(b_in_ready), 64'(3'b001));
        step();
        check("post_rst_grant", 64'(b_out_src), 64'd0);

        // randomized stream of 16 items with 50% out_ready
        rst = 1'b1;
        b_in_valid = 3'b000;
        step();
        rst = 1'b0;
        ptr_m = 0;
        ov_m = 1'b0;
        issued = 0;
        popped = 0;
        cyc = 0;
        for (int k = 0; k < 3; k++) pend[k] = 1'b0;
        while ((popped < 16) && (cyc < 400)) begin
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && (issued < 16) && ($urandom_range(1) == 1)) begin
                    pend[k]  = 1'b1;
                    pdata[k] = 8'(issued * 13 + 5);
                    issued++;
                end
                b_in_valid[k] = pend[k];
                b_in_data[k*8 +: 8] = pend[k] ? pdata[k] : 8'($urandom);
            end
            rdy = 1'($urandom_range(1));
            b_out_ready = rdy;
            #1;
            g = rr_pick(b_in_valid, ptr_m);
            exp_rdy = ((g >= 0) && (!ov_m || rdy)) ? 3'(one3 << g) : 3'b000;
            check("stream_in_ready", 64'(b_in_ready), 64'(exp_rdy));
            if (b_out_valid && rdy) begin
                check("stream_q_occupancy", 64'(q_src.size()), 64'd1);
                if (q_src.size() > 0) begin
                    exp_src  = q_src.pop_front();
                    exp_data = q_data.pop_front();
                    check("stream_out_src",  64'(b_out_src),  64'(exp_src));
                    check("stream_out_data", 64'(b_out_data), 64'(exp_data));
                end
                popped++;
            end
            if ((g >= 0) && (!ov_m || rdy)) begin
                q_src.push_back(g);
                q_data.push_back(int'(pdata[g]));
                pend[g] = 1'b0;
                ptr_m = (g + 1) % 3;
                ov_m = 1'b1;
            end else if (ov_m && rdy) begin
                ov_m = 1'b0;
            end
            step();
            check("stream_out_valid", 64'(b_out_valid), 64'(ov_m));
            cyc++;
        end
        check("stream_count",   64'(popped),        64'd16);
        check("stream_drained", 64'(q_src.size()),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
